// File: rtl/ex_unit_array.sv
// ex_unit_array: per-lane one-cycle ALU/compare execute stage fed by the reservation stations
//   clk, rst               clock; synchronous active-high reset
//   branch_mispredict      flush of all in-flight and about-to-issue ops
//   rs_data[size]          station entries watched lane by lane
//   ex_data_bus[size]      registered result, ready for exactly one cycle
//   rvfi_rs1_v/rvfi_rs2_v  operands of the op being broadcast
package ex_unit_array_pkg;
  localparam int EX_UNITS = 4;
  localparam int ROB_ID_SIZE = 4;
  localparam logic [6:0] op_b_br = 7'b1100011;
  localparam logic [6:0] op_b_imm = 7'b0010011;
  typedef struct packed {
    logic valid;
    logic r1;
    logic r2;
    logic [6:0] opcode;
    logic [2:0] aluop;
    logic [2:0] cmpop;
    logic alu_cmp;
    logic [31:0] rs1_v;
    logic [31:0] rs2_v;
    logic [ROB_ID_SIZE-1:0] rob_id_dest;
  } rs_d;
  typedef struct packed {
    logic ready;
    logic [ROB_ID_SIZE-1:0] rob_id;
    logic [31:0] rd_data;
    logic br_en;
  } ex_data_bus_t;
endpackage

module ex_unit_array
  import ex_unit_array_pkg::*;
#(
  parameter int size = EX_UNITS,
  parameter int rob_size = ROB_ID_SIZE
) (
  input  logic clk,
  input  logic rst,
  input  logic branch_mispredict,
  input  rs_d rs_data [size],
  output ex_data_bus_t ex_data_bus [size],
  output logic [size-1:0][31:0] rvfi_rs1_v,
  output logic [size-1:0][31:0] rvfi_rs2_v
);
  function automatic logic cmp_f(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    return op == 3'b000 ? a == b :
           op == 3'b001 ? a != b :
           op == 3'b100 ? $signed(a) < $signed(b) :
           op == 3'b101 ? $signed(a) >= $signed(b) :
           op == 3'b110 ? a < b :
           op == 3'b111 ? a >= b : 1'b0;
  endfunction
  function automatic logic [31:0] alu_f(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] sra;
    sra = $signed(a) >>> b[4:0];
    return op == 3'b000 ? a + b :
           op == 3'b011 ? a - b :
           op == 3'b100 ? a ^ b :
           op == 3'b110 ? a | b :
           op == 3'b111 ? a & b :
           op == 3'b001 ? a << b[4:0] :
           op == 3'b101 ? a >> b[4:0] : sra;
  endfunction
  for (genvar i = 0; i < size; i++) begin : g_lane
    rs_d e;
    logic issue, cmp, ready_q, ready_d, br_q, br_d;
    logic [rob_size-1:0] rob_q, rob_d;
    logic [31:0] rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
    assign e = rs_data[i];
    // ready_q doubles as the busy bit: both set on issue and clear on the following edge,
    // which keeps the still-valid station entry from issuing twice
    always_comb begin
      issue = e.valid & e.r1 & e.r2 & ~ready_q & ~branch_mispredict & ~rst;
      cmp = cmp_f(e.cmpop, e.rs1_v, e.rs2_v);
      ready_d = issue;
      rob_d = issue ? e.rob_id_dest : rob_q;
      rd_d = !issue ? rd_q : !e.alu_cmp ? alu_f(e.aluop, e.rs1_v, e.rs2_v) :
             e.opcode == op_b_br ? 32'd0 : {31'd0, cmp};
      br_d = issue ? e.alu_cmp & (e.opcode == op_b_br) & cmp : br_q;
      rs1_d = issue ? e.rs1_v : rs1_q;
      rs2_d = !issue ? rs2_q : e.opcode == op_b_imm ? 32'd0 : e.rs2_v;
    end
    always_ff @(posedge clk) begin
      if (rst) begin
        ready_q <= 1'b0;
        rob_q <= '0;
        rd_q <= '0;
        br_q <= 1'b0;
        rs1_q <= '0;
        rs2_q <= '0;
      end else begin
        ready_q <= ready_d;
        rob_q <= rob_d;
        rd_q <= rd_d;
        br_q <= br_d;
        rs1_q <= rs1_d;
        rs2_q <= rs2_d;
      end
    end
    assign ex_data_bus[i] = '{ready: ready_q, rob_id: rob_q, rd_data: rd_q, br_en: br_q};
    assign rvfi_rs1_v[i] = rs1_q;
    assign rvfi_rs2_v[i] = rs2_q;
  end
endmodule

// File: doc/ex_unit_array.md
# ex_unit_array

Per-lane execute stage directly downstream of the reservation stations. Each lane watches the matching station entry, issues as soon as both operands are ready, and computes the ALU or compare result in one cycle. The result is registered and broadcast for exactly one cycle on that lane's `ex_data_bus` entry, which goes to the ROB and back to the stations. The broadcast lets the station free its entry and the ROB mark the instruction complete; `branch_mispredict` squashes all in-flight work.

## Interface
Parameters:
- `size`, default `EX_UNITS`: number of lanes; equals the number of reservation-station entries.
- `rob_size`, default `ROB_ID_SIZE`: ROB id width.

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `branch_mispredict`  in  1  flush; discards every in-flight and about-to-issue op
- `rs_data[size]`  in  `rs_d`  station entries. Fields used: `valid`, `r1`, `r2`, `opcode`, `aluop`, `cmpop`, `alu_cmp`, `rs1_v`, `rs2_v`, `rob_id_dest`.
- `ex_data_bus[size]`  out  `ex_data_bus_t`  per-lane result. Fields: `ready`, `rob_id`, `rd_data[31:0]`, `br_en`.
- `rvfi_rs1_v`, `rvfi_rs2_v`  out  `[size-1:0][31:0]`  operands of the op being broadcast, registered with the result.

## Operation
- Per-lane state: `busy[i]` plus the registered result. Lanes are fully independent; there is no arbitration.
- Issue condition for lane i in cycle t: `rs_data[i].valid & r1 & r2 & ~busy[i] & ~branch_mispredict & ~rst`.
- Compare function, selected by `cmpop`, compares `rs1_v` with `rs2_v`:
  - beq 000, bne 001: equal / not equal
  - blt 100, bge 101: signed less-than / greater-or-equal
  - bltu 110, bgeu 111: unsigned less-than / greater-or-equal
  - any other `cmpop` yields 0
- ALU function, selected by `aluop`:
  - add 000, sub 011, xor 100, or 110, and 111
  - sll 001, srl 101, sra 010 (arithmetic)
  - shift amount is `rs2_v[4:0]`; all arithmetic is mod 2^32 with no overflow flag
- Result selection on issue:
  - `alu_cmp=0`: `rd_data` = ALU result, `br_en` = 0. Covers lui, auipc, jal/jalr target, reg/imm ops.
  - `alu_cmp=1`, `opcode=op_b_br`: `rd_data` = 0, `br_en` = compare result.
  - `alu_cmp=1`, any other opcode (slt/sltu): `rd_data` = {31'b0, compare result}, `br_en` = 0.
- On issue, register the following and set `busy[i]`:
  - `rob_id` ← `rob_id_dest`
  - `rd_data`, `br_en` as selected above
  - `rvfi_rs1_v[i]` ← `rs1_v`; `rvfi_rs2_v[i]` ← `rs2_v`, except it is forced to 0 when `opcode=op_b_imm`
- `busy[i]` clears on the edge that ends the `ready` cycle. Reason: the station entry is still valid during the `ready` cycle, and `busy` prevents a double issue of it.

## Timing
- Latency: operands ready in cycle t → `ex_data_bus[i].ready=1` in cycle t+1, for exactly one cycle.
- Throughput: at most 1 op per lane per 2 cycles. The earliest next issue on the same lane is t+2, which is the first cycle the station can present a new or refilled entry.
- `ready` is never high on two consecutive cycles on the same lane.
- If the station overwrites lane i with a new instruction at the end of the `ready` cycle, that new entry is evaluated normally from t+2.
- Flush: `branch_mispredict` high in cycle t →
  - no issue in cycle t;
  - every `ready` is low in t+1, including any result that would have been issued at t;
  - all `busy` bits are 0 in t+1.
  - A `ready` already being driven in cycle t remains valid in t.
- Reset values of every output:
  - `ready`=0, `rob_id`=0, `rd_data`=0, `br_en`=0
  - `rvfi_rs1_v`=0, `rvfi_rs2_v`=0
  - `busy`=0
- `rst` mid-operation: same as reset; an op issued the cycle before `rst` is dropped, with no `ready` in the cycle after `rst`.
- Non-`ready` cycles: `rob_id`, `rd_data` and `br_en` hold their last values. Consumers must qualify every field with `ready`.

## Test plan
- **ADD:** lane 0 entry `aluop=add`, `rs1_v=5`, `rs2_v=7`, `rob_id_dest=3`, r1=r2=1 → next cycle `ready=1`, `rob_id=3`, `rd_data=12`, `br_en=0`; `ready=0` the cycle after, even with the entry held valid.
- **Signed vs unsigned compare:** SLT with `rs1_v=0xFFFFFFFF`, `rs2_v=1`, `cmpop=blt` → `rd_data=1`. The same operands with `cmpop=bltu` → `rd_data=0`. SRA of `0x80000000` by `rs2_v=0x21` → `0xC0000000`.
- **Branch:** BNE with `rs1_v=4`, `rs2_v=4` → `br_en=0`, `rd_data=0`. BGE with `rs1_v=-1`, `rs2_v=-2` → `br_en=1`.
- **Operand wait:** entry valid with r2=0 for 3 cycles, then r2=1 → no `ready` while waiting; `ready` exactly 1 cycle after r2 rises.
- **Flush:** `branch_mispredict` pulsed in the issue cycle on all lanes → no `ready` on any lane in the next cycle. Next issue after flush behaves normally.
- **Lane independence and reset:** lanes 0 and 1 issue in the same cycle → both `ready` together with their own `rob_id`s. Assert `rst` the cycle after an issue → all outputs 0 and no `ready`.
